frame_write_ctrl: RTL and testbench
===================================

FRAME_WRITE_CTRL -- requirements
Module: frame_write_ctrl

Interface
REQ-001 The module SHALL have parameter FRAME_PIXELS, default 200704, meaning pixels per frame (512x392).
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning idle clk cycles (1 ms at 100 MHz) before a partial pixel is discarded.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port rx_ready, input, 1 bit: one-cycle strobe marking a valid received UART byte.
REQ-006 The module SHALL have port rx_data, input, 8 bits: received byte, valid when rx_ready=1.
REQ-007 The module SHALL have port frame_restart, input, 1 bit: one-cycle strobe (debounced button) that aborts the current frame.
REQ-008 The module SHALL have port addra, output, 18 bits: BRAM port-A write address, equal to the current pixel index.
REQ-009 The module SHALL have port dina, output, 24 bits: assembled pixel {R,G,B}.
REQ-010 The module SHALL have port wea, output, 1 bit: BRAM write enable, one cycle per pixel.
REQ-011 The module SHALL have port frame_done, output, 1 bit: one-cycle strobe issued after the last pixel of a frame is written.
REQ-012 The module SHALL have port busy, output, 1 bit: high while a frame is in progress (state RECV).
REQ-013 The module SHALL have port drop_cnt, output, 8 bits: saturating count of partial pixels discarded by timeout.

Function
REQ-014 The controller SHALL implement states IDLE and RECV, with byte phase 0..2 and pixel index 0..FRAME_PIXELS-1.
REQ-015 IDLE: on rx_ready the controller SHALL store the byte as R (dina[23:16]), set phase=1, and go to RECV.
REQ-016 RECV: phase 1 SHALL store G (dina[15:8]); phase 2 SHALL store B (dina[7:0]) and set phase=0.
REQ-017 wea SHALL be 1 exactly in the cycle after the third byte's rx_ready, with addra = pixel index and dina complete in that same cycle.
REQ-018 The pixel index SHALL increment in the cycle after wea, so addra is stable throughout the write cycle.
REQ-019 When the write is at index FRAME_PIXELS-1, the controller SHALL raise frame_done in the cycle after wea, reset the index to 0, and enter IDLE.
REQ-020 An rx_ready arriving in the wea cycle or the frame_done cycle SHALL be accepted as byte R of the next pixel; no byte is lost.
REQ-021 frame_restart SHALL have priority over rx_ready in the same cycle; it SHALL clear the index and phase, suppress wea and frame_done, enter IDLE, and drop that cycle's byte.
REQ-022 In RECV with phase≠0, TIMEOUT_CYCLES consecutive cycles without rx_ready SHALL reset phase to 0, keep the index, and increment drop_cnt (saturating at 255).
REQ-023 A timeout with phase=0 SHALL have no effect.
REQ-024 The timeout counter SHALL restart on every rx_ready.
REQ-025 Pixel index arithmetic SHALL use 18 bits; the index SHALL never exceed FRAME_PIXELS-1.

Reset
REQ-026 While resetn=0, the outputs SHALL be: addra=0, dina=0, wea=0, frame_done=0, busy=0, drop_cnt=0; state=IDLE; phase=0; timer=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, the next byte SHALL be treated as R of pixel 0.

Configuration
REQ-028 With FRAME_WRITE_CTRL_TIMEOUT_EN defined, REQ-022 to REQ-024 SHALL apply.
REQ-029 Without FRAME_WRITE_CTRL_TIMEOUT_EN, the timer logic SHALL be absent, drop_cnt SHALL be tied to 0, and partial pixels SHALL be cleared only by frame_restart or reset.

Structure
REQ-030 Package frame_write_pkg SHALL hold the state enum (IDLE, RECV), ADDR_W=18, PIX_W=24, and the default FRAME_PIXELS and TIMEOUT_CYCLES values.
REQ-031 The timeout SHALL be a sub-module idle_timer (clear on rx_ready, expire strobe at TIMEOUT_CYCLES), instantiated only when FRAME_WRITE_CTRL_TIMEOUT_EN is defined.

Verification
REQ-032 Bytes 0x12,0x34,0x56 -> exactly one wea pulse with addra=0, dina=0x123456; addra=1 afterwards.
REQ-033 FRAME_PIXELS=4, 12 bytes -> wea at addra 0,1,2,3; then frame_done for one cycle, busy=0, addra=0.
REQ-034 Two bytes, then TIMEOUT_CYCLES=50 idle cycles, then 0xAA,0xBB,0xCC -> drop_cnt=1 and a single wea with dina=0xAABBCC at the unchanged address.
REQ-035 frame_restart coincident with the 2nd byte of pixel 5 -> no wea, addra=0, IDLE; next 3 bytes written at addra=0.
REQ-036 rx_ready in the wea cycle of the last pixel of the frame -> frame_done asserted and that byte latched as R of pixel 0.
REQ-037 resetn pulsed low mid-frame -> all outputs 0 immediately (asynchronously); next frame starts at addra=0.

Source files
------------

// File: rtl/frame_write_pkg.sv
// Shared types and constants for the UART-to-BRAM frame writer.
package frame_write_pkg;

    localparam int unsigned ADDR_W             = 18;
    localparam int unsigned PIX_W              = 24;
    localparam int unsigned FRAME_PIXELS_DEF   = 200704;  // 512x392
    localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;  // 1 ms at 100 MHz

    typedef enum logic {
        IDLE,
        RECV
    } state_e;

endpackage

// File: rtl/frame_write_ctrl_idle_timer.sv
// Idle timer: counts consecutive cycles without clear_i and pulses expire_o on the
// TIMEOUT_CYCLES-th one, then starts over.
module idle_timer
    import frame_write_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expire on the cycle that completes the idle run; count restarts either way.
    always_comb begin
        expire_o = !clear_i && (cnt_q == LAST);
        cnt_d    = cnt_q + CNT_W'(1);
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_write_ctrl.sv
// Assembles UART bytes into 24-bit {R,G,B} pixels and writes them to BRAM port A.
// Define FRAME_WRITE_CTRL_TIMEOUT_EN to discard stale partial pixels after an idle
// period and count them in drop_cnt_o; otherwise drop_cnt_o is tied to 0.
module frame_write_ctrl
    import frame_write_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS   = FRAME_PIXELS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              rx_ready_i,
    input  logic [7:0]        rx_data_i,
    input  logic              frame_restart_i,
    output logic [ADDR_W-1:0] addra_o,
    output logic [PIX_W-1:0]  dina_o,
    output logic              wea_o,
    output logic              frame_done_o,
    output logic              busy_o,
    output logic [7:0]        drop_cnt_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

    if (FRAME_PIXELS == 0 || FRAME_PIXELS > (1 << ADDR_W)) begin : g_bad_frame
        $error("frame_write_ctrl: FRAME_PIXELS out of range");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("frame_write_ctrl: TIMEOUT_CYCLES must be non-zero");
    end

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              wea_q, wea_d;
    logic              done_q, done_d;
    logic              timeout;

`ifdef FRAME_WRITE_CTRL_TIMEOUT_EN
    logic [7:0] drop_q;

    // Timer only runs while a pixel is partially assembled.
    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i   (clk_i),
        .resetn_i(resetn_i),
        .clear_i (rx_ready_i || frame_restart_i || (phase_q == 2'd0)),
        .expire_o(timeout)
    );

    // Saturating count of partial pixels discarded by timeout.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            drop_q <= 8'h00;
        end else if (timeout && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt_o = drop_q;
`else
    assign timeout    = 1'b0;
    assign drop_cnt_o = 8'h00;
`endif

    // Next-state: index advance after a write, byte capture, timeout and restart.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        wea_d   = 1'b0;
        done_d  = 1'b0;

        // Index moves only after the write cycle so addra stays stable during it.
        if (wea_q) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end

        if (timeout) begin
            phase_d = 2'd0;
        end

        // A byte landing in the write or frame_done cycle starts the next pixel.
        if (rx_ready_i) begin
            case (phase_q)
                2'd0: begin
                    pix_d[23:16] = rx_data_i;
                    phase_d      = 2'd1;
                    state_d      = RECV;
                end
                2'd1: begin
                    pix_d[15:8] = rx_data_i;
                    phase_d     = 2'd2;
                end
                default: begin
                    pix_d[7:0] = rx_data_i;
                    phase_d    = 2'd0;
                    wea_d      = 1'b1;
                end
            endcase
        end

        // Restart wins over everything else and drops this cycle's byte.
        if (frame_restart_i) begin
            state_d = IDLE;
            phase_d = 2'd0;
            idx_d   = '0;
            pix_d   = pix_q;
            wea_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            idx_q   <= '0;
            pix_q   <= '0;
            wea_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            wea_q   <= wea_d;
            done_q  <= done_d;
        end
    end

    assign addra_o      = idx_q;
    assign dina_o       = pix_q;
    assign wea_o        = wea_q;
    assign frame_done_o = done_q;
    assign busy_o       = (state_q == RECV);

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl: a per-cycle vector table plus hand-written
// sequences for frame wrap, restart, timeout and asynchronous reset.
module tb_frame_write_ctrl;

    localparam int unsigned FP = 8;
    localparam int unsigned TO = 50;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        frame_restart;
    logic [17:0] addra;
    logic [23:0] dina;
    logic        wea;
    logic        frame_done;
    logic        busy;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    frame_write_ctrl #(
        .FRAME_PIXELS  (FP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .rx_ready_i     (rx_ready),
        .rx_data_i      (rx_data),
        .frame_restart_i(frame_restart),
        .addra_o        (addra),
        .dina_o         (dina),
        .wea_o          (wea),
        .frame_done_o   (frame_done),
        .busy_o         (busy),
        .drop_cnt_o     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [7:0]  data;
        logic        rst;
        logic        wea;
        logic [17:0] addra;
        logic [23:0] dina;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input logic [7:0] data, input logic rst,
                                input logic w, input logic [17:0] a, input logic [23:0] d,
                                input logic dn, input logic b);
        vec_t v;
        v.rdy = rdy; v.data = data; v.rst = rst;
        v.wea = w; v.addra = a; v.dina = d; v.done = dn; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input logic w, input logic [17:0] a,
                             input logic [23:0] d, input logic dn, input logic b);
        chk({tag, ".wea"}, 32'(wea), 32'(w));
        chk({tag, ".addra"}, 32'(addra), 32'(a));
        chk({tag, ".dina"}, 32'(dina), 32'(d));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(dn));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic send(input logic rdy, input logic [7:0] d, input logic rst);
        @(negedge clk);
        rx_ready = rdy; rx_data = d; frame_restart = rst;
        @(posedge clk);
        #1;
        rx_ready = 1'b0; frame_restart = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        send(1'b1, r, 1'b0);
        send(1'b1, g, 1'b0);
        send(1'b1, b, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; frame_restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 18'd0, 24'h0, 1'b0, 1'b0);
        chk("reset.drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Basic assembly, back-to-back pixels, byte in write cycle, restart behaviour.
        vecs.push_back(mk(1, 8'h12, 0, 0, 0, 24'h120000, 0, 1));
        vecs.push_back(mk(1, 8'h34, 0, 0, 0, 24'h123400, 0, 1));
        vecs.push_back(mk(1, 8'h56, 0, 1, 0, 24'h123456, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 24'h123456, 0, 1));
        vecs.push_back(mk(1, 8'hAB, 0, 0, 1, 24'hAB3456, 0, 1));
        vecs.push_back(mk(1, 8'hCD, 0, 0, 1, 24'hABCD56, 0, 1));
        vecs.push_back(mk(1, 8'hEF, 0, 1, 1, 24'hABCDEF, 0, 1));
        vecs.push_back(mk(1, 8'h01, 0, 0, 2, 24'h01CDEF, 0, 1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 2, 24'h0102EF, 0, 1));
        vecs.push_back(mk(1, 8'h03, 0, 1, 2, 24'h010203, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 3, 24'h010203, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 24'h010203, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 24'h010203, 0, 0));
        vecs.push_back(mk(1, 8'h44, 1, 0, 0, 24'h010203, 0, 0));
        vecs.push_back(mk(1, 8'h55, 0, 0, 0, 24'h550203, 0, 1));
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].rdy, vecs[i].data, vecs[i].rst);
            check_out($sformatf("vec%0d", i), vecs[i].wea, vecs[i].addra, vecs[i].dina,
                      vecs[i].done, vecs[i].busy);
        end

        // Full frame, bytes back to back; one write per pixel then frame_done.
        do_reset();
        for (int p = 0; p < FP; p++) begin
            send(1'b1, 8'(8'h10 + p), 1'b0);
            chk($sformatf("frame.p%0d.r_wea", p), 32'(wea), 32'd0);
            send(1'b1, 8'(8'h20 + p), 1'b0);
            chk($sformatf("frame.p%0d.g_wea", p), 32'(wea), 32'd0);
            send(1'b1, 8'(8'h30 + p), 1'b0);
            check_out($sformatf("frame.p%0d", p), 1'b1, 18'(p),
                      {8'(8'h10 + p), 8'(8'h20 + p), 8'(8'h30 + p)}, 1'b0, 1'b1);
        end
        idle(1);
        check_out("frame.done", 1'b0, 18'd0, 24'h172737, 1'b1, 1'b0);
        idle(1);
        chk("frame.done_one_cycle", 32'(frame_done), 32'd0);

        // Byte arriving in the last pixel's write cycle becomes R of pixel 0.
        do_reset();
        for (int p = 0; p < FP; p++) send_pixel(8'(8'h10 + p), 8'(8'h20 + p), 8'(8'h30 + p));
        check_out("wrap.last_write", 1'b1, 18'(FP - 1), 24'h172737, 1'b0, 1'b1);
        send(1'b1, 8'h99, 1'b0);
        check_out("wrap.done", 1'b0, 18'd0, 24'h992737, 1'b1, 1'b1);
        send(1'b1, 8'h88, 1'b0);
        send(1'b1, 8'h77, 1'b0);
        check_out("wrap.pix0", 1'b1, 18'd0, 24'h998877, 1'b0, 1'b1);

        // Restart coincident with the 2nd byte of pixel 5.
        do_reset();
        for (int p = 0; p < 5; p++) send_pixel(8'h01, 8'h02, 8'h03);
        idle(1);
        chk("restart.pre_addra", 32'(addra), 32'd5);
        send(1'b1, 8'h61, 1'b0);
        send(1'b1, 8'h62, 1'b1);
        check_out("restart.hit", 1'b0, 18'd0, 24'h610203, 1'b0, 1'b0);
        send_pixel(8'h71, 8'h72, 8'h73);
        check_out("restart.next", 1'b1, 18'd0, 24'h717273, 1'b0, 1'b1);
        idle(1);
        chk("restart.addra_after", 32'(addra), 32'd1);

        // One cycle short of the timeout: partial pixel survives.
        do_reset();
        send(1'b1, 8'h12, 1'b0);
        idle(TO - 1);
        send(1'b1, 8'h34, 1'b0);
        send(1'b1, 8'h56, 1'b0);
        check_out("to_short", 1'b1, 18'd0, 24'h123456, 1'b0, 1'b1);
        chk("to_short.drop_cnt", 32'(drop_cnt), 32'd0);

        // Two bytes, a full idle period, then a fresh pixel.
        do_reset();
        send(1'b1, 8'h12, 1'b0);
        send(1'b1, 8'h34, 1'b0);
        idle(TO);
`ifdef FRAME_WRITE_CTRL_TIMEOUT_EN
        chk("timeout.drop_cnt", 32'(drop_cnt), 32'd1);
        chk("timeout.addra", 32'(addra), 32'd0);
        send_pixel(8'hAA, 8'hBB, 8'hCC);
        check_out("timeout.pix", 1'b1, 18'd0, 24'hAABBCC, 1'b0, 1'b1);
        chk("timeout.drop_cnt_after", 32'(drop_cnt), 32'd1);

        // Drop counter saturates at 255.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 8'h5A, 1'b0);
            idle(TO);
        end
        chk("timeout.saturate", 32'(drop_cnt), 32'd255);
`else
        chk("no_timeout.drop_cnt", 32'(drop_cnt), 32'd0);
        send(1'b1, 8'hAA, 1'b0);
        check_out("no_timeout.pix", 1'b1, 18'd0, 24'h1234AA, 1'b0, 1'b1);
        send(1'b1, 8'hBB, 1'b0);
        send(1'b1, 8'hCC, 1'b0);
        check_out("no_timeout.partial", 1'b0, 18'd1, 24'hBBCCAA, 1'b0, 1'b1);
`endif

        // Asynchronous reset mid-frame, between clock edges.
        do_reset();
        send_pixel(8'h01, 8'h02, 8'h03);
        send_pixel(8'h04, 8'h05, 8'h06);
        send(1'b1, 8'h07, 1'b0);
        chk("areset.pre_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_out("areset.now", 1'b0, 18'd0, 24'h0, 1'b0, 1'b0);
        chk("areset.drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        send_pixel(8'hDE, 8'hAD, 8'hBE);
        check_out("areset.after", 1'b1, 18'd0, 24'hDEADBE, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
